// File: rtl/dp_share_pkg.sv
// Shared definitions for the two-client divider sequencer.
//   state_t   : controller state encoding (IDLE/LOAD/SUB/CHK/DONE)
//   W_DEF     : default datapath / operand width
//   MAX_Q_DEF : default quotient guard; a count beyond it aborts the op
//   N_REQ     : number of requesters sharing the datapath
package dp_share_pkg;

  localparam int W_DEF     = 8;
  localparam int MAX_Q_DEF = 127;
  localparam int N_REQ     = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SUB  = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a last-served pointer.
// Build option: DP_SHARE_FIXED_PRIO_EN -- when defined, requester 0 always
// wins a tie and the pointer register is removed.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : pending requests
//   advance    : one-cycle pulse when the served requester releases
//   served     : index of the requester that was just served
//   gnt        : index of the requester that would be granted now
//   valid      : at least one request is pending
module rr_arb2
  import dp_share_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  input  logic             served,
  output logic             gnt,
  output logic             valid
);

  assign valid = |req;

`ifdef DP_SHARE_FIXED_PRIO_EN
  // No state needed: requester 0 wins whenever it is asking.
  logic unused_ok;
  assign unused_ok = ^{clk, reset, advance, served};
  assign gnt = ~req[0];
`else
  // last = index of the requester served most recently. Reset value 1 makes
  // requester 0 win the first tie.
  logic last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= served;
    end
  end

  always_comb begin
    gnt = req[1];
    if (req[0] && req[1]) begin
      gnt = ~last;
    end
  end
`endif

endmodule

// File: rtl/dp_share_ctrl.sv
// Sequencer/arbiter sharing one repeated-subtraction divider datapath
// between two requesters.
// Build option: DP_SHARE_FIXED_PRIO_EN (see rr_arb2) selects fixed priority
// instead of round-robin.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   req0/req1           : requests; operands a0,b0 / a1,b1 held stable
//   ack0/ack1           : result valid for that requester
//   q, rem, err         : quotient, remainder, error (valid while an ack is high)
//   owner               : current or last granted requester
//   dp_a, dp_b          : operands to datapath (0 outside an op)
//   dp_l, dp_s          : datapath load / subtract strobes
//   dp_r                : datapath R register (MSB is the sign)
//   dbg_state           : current controller state
//
// Handshake (four-phase): a requester raises req with stable operands; the
// block raises that requester's ack with q/rem/err valid and holds it until
// req drops; ack falls on the next edge after req is seen low. A request that
// arrives while another op runs waits and is served later.
module dp_share_ctrl
  import dp_share_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int MAX_Q = MAX_Q_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] q,
  output logic [W-1:0] rem,
  output logic         err,
  output logic         owner,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic         dp_l,
  output logic         dp_s,
  input  logic [W-1:0] dp_r,
  output logic [2:0]   dbg_state
);

  localparam logic [W:0] MAX_Q_V = MAX_Q[W:0];

  state_t         state, state_nxt;
  logic           owner_r;
  logic [W-1:0]   cnt;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   q_r;
  logic [W-1:0]   rem_r;
  logic           err_r;

  logic           arb_gnt;
  logic           arb_valid;
  logic           arb_adv;
  logic           req_own;
  logic [W-1:0]   ga;
  logic [W-1:0]   gb;
  logic           bad;
  logic [W:0]     cnt_inc;
  logic           op_act;

  assign req_own = owner_r ? req1 : req0;
  assign arb_adv = (state == DONE) && !req_own;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (arb_adv),
    .served  (owner_r),
    .gnt     (arb_gnt),
    .valid   (arb_valid)
  );

  // Operand screening on the pair that would be granted this cycle:
  // zero divisor or a set sign bit is rejected without touching the datapath.
  assign ga  = arb_gnt ? a1 : a0;
  assign gb  = arb_gnt ? b1 : b0;
  assign bad = (gb == '0) || ga[W-1] || gb[W-1];

  // One extra bit so the guard compare cannot wrap.
  assign cnt_inc = {1'b0, cnt} + {{W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (arb_valid) state_nxt = bad ? DONE : LOAD;
      LOAD: state_nxt = SUB;
      SUB:  state_nxt = CHK;
      CHK: begin
        if (dp_r[W-1]) begin
          state_nxt = DONE;
        end else if (cnt_inc > MAX_Q_V) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SUB;
        end
      end
      DONE: if (!req_own) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rem_q keeps the value of R from before the last subtraction: once R goes
  // negative, that earlier value is the remainder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r <= 1'b0;
      cnt     <= '0;
      rem_q   <= '0;
      q_r     <= '0;
      rem_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner_r <= arb_gnt;
            cnt     <= '0;
            if (bad) begin
              err_r <= 1'b1;
              q_r   <= '0;
              rem_r <= '0;
            end
          end
        end
        SUB: rem_q <= dp_r;
        CHK: begin
          if (dp_r[W-1]) begin
            q_r   <= cnt;
            rem_r <= rem_q;
            err_r <= 1'b0;
          end else begin
            cnt <= cnt_inc[W-1:0];
            if (cnt_inc > MAX_Q_V) begin
              err_r <= 1'b1;
              q_r   <= '0;
              rem_r <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign op_act    = (state == LOAD) || (state == SUB) || (state == CHK);
  assign dp_l      = (state == LOAD);
  assign dp_s      = (state == SUB);
  assign dp_a      = op_act ? (owner_r ? a1 : a0) : '0;
  assign dp_b      = op_act ? (owner_r ? b1 : b0) : '0;
  assign ack0      = (state == DONE) && !owner_r;
  assign ack1      = (state == DONE) && owner_r;
  assign q         = q_r;
  assign rem       = rem_r;
  assign err       = err_r;
  assign owner     = owner_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_dp_share_ctrl.sv
// Self-checking bench for dp_share_ctrl with a behavioural divider datapath.
module tb_dp_share_ctrl;

  localparam int W  = 8;
  localparam int SW = 2 * W + 2;   // {owner, err, q, rem}

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, err, owner, dp_l, dp_s;
  logic [W-1:0] q, rem, dp_a, dp_b, dp_r;
  logic [2:0]   dbg_state;

  int checks = 0;
  int passes = 0;
  logic [SW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dp_share_ctrl #(.W(W), .MAX_Q(127)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1),
    .q(q), .rem(rem), .err(err), .owner(owner),
    .dp_a(dp_a), .dp_b(dp_b), .dp_l(dp_l), .dp_s(dp_s),
    .dp_r(dp_r), .dbg_state(dbg_state)
  );

  // ---------------- datapath model and strobe monitors ----------------
  logic [W-1:0] r_reg = '0, b_reg = '0;
  assign dp_r = r_reg;

  always @(posedge clk) begin
    if (dp_l) begin
      r_reg <= dp_a;
      b_reg <= dp_b;
    end else if (dp_s) begin
      r_reg <= r_reg - b_reg;
    end
  end

  int dl_cnt = 0, ds_cnt = 0, bad_cnt = 0;
  always @(posedge clk) begin
    if (dp_l) dl_cnt <= dl_cnt + 1;
    if (dp_s) ds_cnt <= ds_cnt + 1;
    if ((dp_l && dp_s) || (ack0 && ack1)) bad_cnt <= bad_cnt + 1;
  end

  // Reference result: plain integer division on screened operands.
  function automatic logic [SW-1:0] model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] qq, rr;
    if (b == '0 || a[W-1] || b[W-1]) return {id, 1'b1, {W{1'b0}}, {W{1'b0}}};
    qq = a / b;
    rr = a % b;
    return {id, 1'b0, qq, rr};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin a0 = a; b0 = b; req0 = 1'b1; end
    else         begin a1 = a; b1 = b; req1 = 1'b1; end
  endtask

  // sel: 0 -> ack0, 1 -> ack1, 2 -> either. Counts edges until seen.
  task automatic wait_ack(input int sel, output int edges, output logic hit);
    edges = 0;
    hit = 1'b0;
    while (!hit && edges < 400) begin
      @(negedge clk);
      edges++;
      hit = (sel == 0) ? ack0 : (sel == 1) ? ack1 : (ack0 | ack1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({ack0, ack1, q, rem, err, owner, dp_a, dp_b, dp_l, dp_s, dbg_state} !== '0)
      $display("FAIL reset_outputs: got ack=%b%b q=%0d rem=%0d err=%b owner=%b dp_a=%0d dp_b=%0d l=%b s=%b st=%0d, need all 0",
               ack0, ack1, q, rem, err, owner, dp_a, dp_b, dp_l, dp_s, dbg_state);
    else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Lone requester: latency, result, strobe counts, hold in DONE, release.
  task automatic test_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int edges, lb, sb, exp_lat, exp_l, exp_s;
    logic hit, rej;
    logic [SW-1:0] exp, got;
    rej = (b == '0) || a[W-1] || b[W-1];
    // Edges counted from driving req: one sampling edge plus 2q+3 (0 for a reject).
    exp_lat = rej ? 1 : 2 * int'(a / b) + 4;
    exp_l   = rej ? 0 : 1;
    exp_s   = rej ? 0 : int'(a / b) + 1;
    exp_q.push_back(model(id[0], a, b));
    lb = dl_cnt;
    sb = ds_cnt;
    drive_op(id, a, b);
    wait_ack(id, edges, hit);
    checks++;
    if (!hit || edges != exp_lat)
      $display("FAIL latency id=%0d %0d/%0d: got %0d edges (ack seen=%b), need %0d", id, a, b, edges, hit, exp_lat);
    else passes++;
    exp = exp_q.pop_front();
    got = {owner, err, q, rem};
    checks++;
    if (got !== exp)
      $display("FAIL result id=%0d %0d/%0d: got owner=%b err=%b q=%0d rem=%0d, need owner=%b err=%b q=%0d rem=%0d",
               id, a, b, got[SW-1], got[SW-2], got[2*W-1:W], got[W-1:0], exp[SW-1], exp[SW-2], exp[2*W-1:W], exp[W-1:0]);
    else passes++;
    checks++;
    if (dl_cnt - lb != exp_l) $display("FAIL load_pulses id=%0d: got %0d, need %0d", id, dl_cnt - lb, exp_l);
    else passes++;
    checks++;
    if (ds_cnt - sb != exp_s) $display("FAIL sub_pulses id=%0d: got %0d, need %0d", id, ds_cnt - sb, exp_s);
    else passes++;
    checks++;
    if ((id == 0 ? ack1 : ack0) !== 1'b0) $display("FAIL other_ack id=%0d: got 1, need 0", id);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if ({(id == 0 ? ack0 : ack1), owner, err, q, rem} !== {1'b1, exp})
      $display("FAIL hold id=%0d: got ack=%b q=%0d rem=%0d err=%b, need ack=1 q=%0d rem=%0d err=%b",
               id, (id == 0 ? ack0 : ack1), q, rem, err, exp[2*W-1:W], exp[W-1:0], exp[SW-2]);
    else passes++;
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b00) $display("FAIL ack_release id=%0d: got ack=%b%b, need 00", id, ack0, ack1);
    else passes++;
  endtask

  // Both requests raised together from idle; `first` is who must win.
  task automatic test_contention(input logic first);
    int edges;
    logic hit;
    logic [SW-1:0] exp;
    exp_q.push_back(model(first, first ? 8'd7 : 8'd9, first ? 8'd7 : 8'd2));
    exp_q.push_back(model(~first, first ? 8'd9 : 8'd7, first ? 8'd2 : 8'd7));
    a0 = 8'd9; b0 = 8'd2; a1 = 8'd7; b1 = 8'd7;
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_ack(2, edges, hit);
      exp = exp_q.pop_front();
      checks++;
      if ({hit, owner, err, q, rem} !== {1'b1, exp})
        $display("FAIL contention_%0d: got ack=%b owner=%b err=%b q=%0d rem=%0d, need owner=%b err=%b q=%0d rem=%0d",
                 k, hit, owner, err, q, rem, exp[SW-1], exp[SW-2], exp[2*W-1:W], exp[W-1:0]);
      else passes++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen, guard;
    drive_op(0, 8'd100, 8'd3);
    seen = 0;
    guard = 0;
    while (seen < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (dp_s) seen++;
    end
    checks++;
    if (seen != 5) $display("FAIL reset_mid_reach_sub: got %0d sub cycles, need 5", seen);
    else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, q, rem, err, owner, dp_a, dp_b, dp_l, dp_s, dbg_state} !== '0)
      $display("FAIL reset_mid_outputs: got ack=%b%b q=%0d rem=%0d err=%b owner=%b dp_a=%0d dp_b=%0d l=%b s=%b, need all 0",
               ack0, ack1, q, rem, err, owner, dp_a, dp_b, dp_l, dp_s);
    else passes++;
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_single(0, 8'd100, 8'd3);
  endtask

  // req0 finishes and re-requests as soon as its ack is low, with req1 waiting.
  task automatic test_back_to_back();
    int edges;
    logic hit;
    logic [SW-1:0] exp;
    exp_q.push_back(model(1'b0, 8'd20, 8'd6));
    drive_op(0, 8'd20, 8'd6);
    @(negedge clk);
    drive_op(1, 8'd13, 8'd5);
    wait_ack(0, edges, hit);
    exp = exp_q.pop_front();
    checks++;
    if ({hit, owner, err, q, rem} !== {1'b1, exp})
      $display("FAIL b2b_first: got ack=%b owner=%b q=%0d rem=%0d, need owner=0 q=%0d rem=%0d",
               hit, owner, q, rem, exp[2*W-1:W], exp[W-1:0]);
    else passes++;
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0) $display("FAIL b2b_ack_drop: got %b, need 0", ack0);
    else passes++;
    drive_op(0, 8'd30, 8'd7);
`ifdef DP_SHARE_FIXED_PRIO_EN
    exp_q.push_back(model(1'b0, 8'd30, 8'd7));
    exp_q.push_back(model(1'b1, 8'd13, 8'd5));
`else
    exp_q.push_back(model(1'b1, 8'd13, 8'd5));
    exp_q.push_back(model(1'b0, 8'd30, 8'd7));
`endif
    for (int k = 0; k < 2; k++) begin
      wait_ack(2, edges, hit);
      exp = exp_q.pop_front();
      checks++;
      if ({hit, owner, err, q, rem} !== {1'b1, exp})
        $display("FAIL b2b_order_%0d: got ack=%b owner=%b err=%b q=%0d rem=%0d, need owner=%b err=%b q=%0d rem=%0d",
                 k, hit, owner, err, q, rem, exp[SW-1], exp[SW-2], exp[2*W-1:W], exp[W-1:0]);
      else passes++;
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int id;
    logic [W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      id = int'($urandom_range(0, 1));
      a  = W'($urandom_range(0, 127));
      b  = W'($urandom_range(0, 15));
      test_single(id, a, b);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single(0, 8'd3, 8'd8);
    test_single(1, 8'd8, 8'd4);
    test_single(0, 8'd5, 8'd0);
    test_single(0, 8'h90, 8'd3);
    test_single(1, 8'd4, 8'h80);
    test_contention(1'b0);
    // A solo req0 op leaves requester 0 as the last one served.
    test_single(0, 8'd10, 8'd4);
`ifdef DP_SHARE_FIXED_PRIO_EN
    test_contention(1'b0);
`else
    test_contention(1'b1);
`endif
    test_random();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (bad_cnt != 0) $display("FAIL exclusive_strobes: got %0d overlap cycles, need 0", bad_cnt);
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left, need 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
